// File: rtl/board_manager_pkg.sv
// Shared types, constants and cell helpers for the tic-tac-toe board manager.
// Cells are packed two bits each, row-major, cell i at bits [2i+1:2i].
package board_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } cell_t;

  typedef logic [3:0] pos_t;

  localparam pos_t MAX_POS = 4'd8;
  localparam int   BOARD_W = 18;

  typedef logic [BOARD_W-1:0] board_t;

  // Rows, columns, then the two diagonals.
  localparam logic [0:7][0:2][3:0] WIN_LINES = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SEARCH,
    ST_EVAL
  } state_t;

  // Out-of-range positions read as EMPTY so callers never index past the board.
  function automatic cell_t cell_at(board_t b, pos_t p);
    cell_t c;
    c = EMPTY;
    for (int i = 0; i <= int'(MAX_POS); i++) begin
      if (p == pos_t'(i)) c = cell_t'(b[2*i +: 2]);
    end
    return c;
  endfunction

  function automatic board_t put_cell(board_t b, pos_t p, cell_t c);
    board_t r;
    r = b;
    for (int i = 0; i <= int'(MAX_POS); i++) begin
      if (p == pos_t'(i)) r[2*i +: 2] = c;
    end
    return r;
  endfunction

  function automatic cell_t mark_of(logic player);
    return player ? MARK_O : MARK_X;
  endfunction

endpackage

// File: rtl/board_manager_if.sv
// Command/status bundle between the game controller and the board manager.
// The controller is the master: it issues command pulses and reads status.
interface board_manager_if;
  import board_pkg::*;

  logic   new_game;
  logic   play_req;
  pos_t   play_pos;
  logic   random_req;
  logic   validate_win;
  logic   change_turn;

  logic   busy;
  logic   valid;
  logic   invalid;
  pos_t   last_pos;
  logic   player;
  logic   win;
  logic   tie;
  board_t board;

  modport master (
    output new_game, play_req, play_pos, random_req, validate_win, change_turn,
    input  busy, valid, invalid, last_pos, player, win, tie, board
  );

  modport slave (
    input  new_game, play_req, play_pos, random_req, validate_win, change_turn,
    output busy, valid, invalid, last_pos, player, win, tie, board
  );

endinterface

// File: rtl/board_line_detect.sv
// Combinational line and fullness detector for one mark on the packed board.
// line: some row/column/diagonal holds three of mark; full: no empty cell left.
module board_line_detect
  import board_pkg::*;
(
  input  board_t board,
  input  cell_t  mark,
  output logic   line,
  output logic   full
);

  // NOTE: every output gets a default before the loops so no latch is inferred.
  always_comb begin
    line = 1'b0;
    full = 1'b1;
    for (int l = 0; l < 8; l++) begin
      if (cell_at(board, WIN_LINES[l][0]) == mark &&
          cell_at(board, WIN_LINES[l][1]) == mark &&
          cell_at(board, WIN_LINES[l][2]) == mark)
        line = 1'b1;
    end
    for (int i = 0; i <= int'(MAX_POS); i++) begin
      if (board[2*i +: 2] == EMPTY) full = 1'b0;
    end
  end

endmodule

// File: rtl/board_manager.sv
// Owns the 3x3 board: executes play/random/validate/turn command pulses from
// the game controller and reports valid/invalid, win, tie and current player.
module board_manager
  import board_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         NUM_CELLS = 9
) (
  input  logic            clk,
  input  logic            rst,
  board_manager_if.slave  bus
);

  state_t     state, state_next;
  board_t     board;
  logic       player;
  logic       win, tie;
  logic       valid, invalid, busy;
  pos_t       last_pos;
  logic [7:0] lfsr;
  pos_t       req_pos;
  pos_t       probe_idx;
  logic [3:0] probe_cnt;

  logic line_cur, line_x, line_o;
  logic full_cur, full_x, full_o;
  logic board_full;

  board_line_detect u_detect_cur (
    .board (board),
    .mark  (mark_of(player)),
    .line  (line_cur),
    .full  (full_cur)
  );

  board_line_detect u_detect_x (
    .board (board),
    .mark  (MARK_X),
    .line  (line_x),
    .full  (full_x)
  );

  board_line_detect u_detect_o (
    .board (board),
    .mark  (MARK_O),
    .line  (line_o),
    .full  (full_o)
  );

  assign board_full = full_cur & full_x & full_o;

  // Fold the 4-bit LFSR slice into 0..8 for the search start cell.
  pos_t lfsr_low, rand_start;
  assign lfsr_low   = lfsr[3:0];
  assign rand_start = (lfsr_low > MAX_POS) ? lfsr_low - 4'd9 : lfsr_low;

  logic lfsr_fb;
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  logic clear_game, start_check, start_search, step_probe;
  logic do_write, do_eval, do_toggle;
  logic set_valid, set_invalid;
  pos_t write_pos;

  always_comb begin
    state_next   = state;
    clear_game   = 1'b0;
    start_check  = 1'b0;
    start_search = 1'b0;
    step_probe   = 1'b0;
    do_write     = 1'b0;
    do_eval      = 1'b0;
    do_toggle    = 1'b0;
    set_valid    = 1'b0;
    set_invalid  = 1'b0;
    write_pos    = req_pos;

    if (bus.new_game) begin
      clear_game = 1'b1;
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.play_req) begin
            start_check = 1'b1;
            state_next  = ST_CHECK;
          end else if (bus.random_req) begin
            start_search = 1'b1;
            state_next   = ST_SEARCH;
          end else if (bus.validate_win) begin
            state_next = ST_EVAL;
          end else if (bus.change_turn && !win && !tie) begin
            do_toggle = 1'b1;
          end
        end

        ST_CHECK: begin
          state_next = ST_IDLE;
          if (req_pos <= MAX_POS && cell_at(board, req_pos) == EMPTY && !win && !tie) begin
            do_write  = 1'b1;
            set_valid = 1'b1;
          end else begin
            set_invalid = 1'b1;
          end
        end

        ST_SEARCH: begin
          write_pos = probe_idx;
          if (win || tie) begin
            set_invalid = 1'b1;
            state_next  = ST_IDLE;
          end else if (cell_at(board, probe_idx) == EMPTY) begin
            do_write   = 1'b1;
            set_valid  = 1'b1;
            state_next = ST_IDLE;
          end else if (probe_cnt == 4'(NUM_CELLS - 1)) begin
            set_invalid = 1'b1;
            state_next  = ST_IDLE;
          end else begin
            step_probe = 1'b1;
          end
        end

        ST_EVAL: begin
          do_eval    = 1'b1;
          state_next = ST_IDLE;
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  // Every register, including the scratch req_pos/probe state, is reset so the
  // block comes up in a known state with no X propagation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      board     <= '0;
      player    <= 1'b0;
      win       <= 1'b0;
      tie       <= 1'b0;
      valid     <= 1'b0;
      invalid   <= 1'b0;
      busy      <= 1'b0;
      last_pos  <= '0;
      lfsr      <= LFSR_SEED;
      req_pos   <= '0;
      probe_idx <= '0;
      probe_cnt <= '0;
    end else begin
      state   <= state_next;
      lfsr    <= {lfsr[6:0], lfsr_fb};
      valid   <= set_valid;
      invalid <= set_invalid;

      if (clear_game) begin
        board    <= '0;
        player   <= 1'b0;
        win      <= 1'b0;
        tie      <= 1'b0;
        last_pos <= '0;
        busy     <= 1'b0;
      end else begin
        if (start_check) req_pos <= bus.play_pos;

        if (start_search) begin
          probe_idx <= rand_start;
          probe_cnt <= '0;
          busy      <= 1'b1;
        end

        if (step_probe) begin
          probe_idx <= (probe_idx == MAX_POS) ? '0 : probe_idx + 4'd1;
          probe_cnt <= probe_cnt + 4'd1;
        end

        if (set_valid || set_invalid) busy <= 1'b0;

        if (do_write) begin
          board    <= put_cell(board, write_pos, mark_of(player));
          last_pos <= write_pos;
        end

        // A tie needs no line for either mark, so win and tie stay exclusive.
        if (do_eval) begin
          win <= win | line_cur;
          tie <= tie | (board_full & ~line_x & ~line_o & ~win);
        end

        if (do_toggle) player <= ~player;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.valid    = valid;
  assign bus.invalid  = invalid;
  assign bus.last_pos = last_pos;
  assign bus.player   = player;
  assign bus.win      = win;
  assign bus.tie      = tie;
  assign bus.board    = board;

endmodule
